// File: rtl/circular_buff_mp_if.sv
// Bus bundle for the multi-port circular buffer: producer/consumer controls plus status.
// The master modport is the side that drives requests; slave is the buffer itself.
interface circular_buff_mp_if #(
    parameter int LENGTH = 32,
    parameter int SIZE   = 8,
    parameter int PUSH_W = 2,
    parameter int PULL_W = 2
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int HW = $clog2(PUSH_W + 1);
    localparam int LW = $clog2(PULL_W + 1);

    logic                     flush;
    logic [HW-1:0]            push_cnt;
    logic [PUSH_W*LENGTH-1:0] data_write;
    logic [LW-1:0]            pull_cnt;
    logic [PULL_W*LENGTH-1:0] data_read;
    logic [PULL_W-1:0]        rd_valid;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic [PW-1:0]            write_ptr;
    logic [PW-1:0]            read_ptr;
    logic                     overflow_err;
    logic                     underflow_err;

    modport master (
        output flush, push_cnt, data_write, pull_cnt,
        input  data_read, rd_valid, count, full, empty, almost_full,
               write_ptr, read_ptr, overflow_err, underflow_err
    );

    modport slave (
        input  flush, push_cnt, data_write, pull_cnt,
        output data_read, rd_valid, count, full, empty, almost_full,
               write_ptr, read_ptr, overflow_err, underflow_err
    );
endinterface

// File: rtl/circular_buff_mp.sv
// Multi-port FWFT circular buffer: up to PUSH_W writes and PULL_W reads per cycle,
// single-cycle flush, sticky overflow/underflow flags.
module circular_buff_mp #(
    parameter int LENGTH    = 32,
    parameter int SIZE      = 8,
    parameter int PUSH_W    = 2,
    parameter int PULL_W    = 2,
    parameter int AFULL_THR = 6
) (
    input logic              clk,
    input logic              rst,
    circular_buff_mp_if.slave bus
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int HW = $clog2(PUSH_W + 1);
    localparam int LW = $clog2(PULL_W + 1);

    logic [LENGTH-1:0] mem [SIZE];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              ovf_q;
    logic              unf_q;

    logic              push_ok;
    logic              pull_ok;
    logic [CW:0]       space;
    logic [CW-1:0]     push_amt;
    logic [CW-1:0]     pull_amt;

    // Both requests are judged against the pre-edge occupancy; no same-cycle credit.
    always_comb begin
        space    = (CW+1)'(SIZE) - {1'b0, count_q};
        push_ok  = (bus.push_cnt <= HW'(PUSH_W)) && ((CW+1)'(bus.push_cnt) <= space);
        pull_ok  = (bus.pull_cnt <= LW'(PULL_W)) && ((CW+1)'(bus.pull_cnt) <= {1'b0, count_q});
        push_amt = push_ok ? CW'(bus.push_cnt) : '0;
        pull_amt = pull_ok ? CW'(bus.pull_cnt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_amt);
            rd_ptr_q <= rd_ptr_q + PW'(pull_amt);
            count_q  <= count_q + push_amt - pull_amt;
            if (!push_ok) ovf_q <= 1'b1;
            if (!pull_ok) unf_q <= 1'b1;
        end
    end

    // Storage is deliberately not reset; lanes past count are don't-care.
    always_ff @(posedge clk) begin
        if (!bus.flush && push_ok) begin
            for (int k = 0; k < PUSH_W; k++) begin
                if (k < int'(bus.push_cnt))
                    mem[wr_ptr_q + PW'(k)] <= bus.data_write[k*LENGTH +: LENGTH];
            end
        end
    end

    always_comb begin
        bus.data_read = '0;
        bus.rd_valid  = '0;
        for (int k = 0; k < PULL_W; k++) begin
            bus.data_read[k*LENGTH +: LENGTH] = mem[rd_ptr_q + PW'(k)];
            bus.rd_valid[k]                   = count_q > CW'(k);
        end
    end

    assign bus.count         = count_q;
    assign bus.full          = (count_q == CW'(SIZE));
    assign bus.empty         = (count_q == '0);
    assign bus.almost_full   = (count_q >= CW'(AFULL_THR));
    assign bus.write_ptr     = wr_ptr_q;
    assign bus.read_ptr      = rd_ptr_q;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_circular_buff_mp.sv
// Self-checking bench for circular_buff_mp: directed corner cases then random traffic
// against a queue-based reference model.
module tb_circular_buff_mp;
    localparam int LENGTH = 32;
    localparam int SIZE   = 8;
    localparam int PUSH_W = 2;
    localparam int PULL_W = 2;
    localparam int AFULL  = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circular_buff_mp_if #(.LENGTH(LENGTH), .SIZE(SIZE), .PUSH_W(PUSH_W), .PULL_W(PULL_W)) bus ();

    circular_buff_mp #(
        .LENGTH(LENGTH), .SIZE(SIZE), .PUSH_W(PUSH_W), .PULL_W(PULL_W), .AFULL_THR(AFULL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [LENGTH-1:0] q[$];
    int m_wp, m_rp;
    bit m_ovf, m_unf;
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic check_all(input string ctx);
        logic [PULL_W-1:0] vexp;
        vexp = '0;
        for (int k = 0; k < PULL_W; k++) if (k < q.size()) vexp[k] = 1'b1;
        chk({ctx, ".count"},       64'(bus.count),         64'(q.size()));
        chk({ctx, ".full"},        64'(bus.full),          64'(q.size() == SIZE));
        chk({ctx, ".empty"},       64'(bus.empty),         64'(q.size() == 0));
        chk({ctx, ".almost_full"}, 64'(bus.almost_full),   64'(q.size() >= AFULL));
        chk({ctx, ".write_ptr"},   64'(bus.write_ptr),     64'(m_wp));
        chk({ctx, ".read_ptr"},    64'(bus.read_ptr),      64'(m_rp));
        chk({ctx, ".overflow"},    64'(bus.overflow_err),  64'(m_ovf));
        chk({ctx, ".underflow"},   64'(bus.underflow_err), 64'(m_unf));
        chk({ctx, ".rd_valid"},    64'(bus.rd_valid),      64'(vexp));
        for (int k = 0; k < PULL_W; k++)
            if (k < q.size())
                chk({ctx, ".lane"}, 64'(bus.data_read[k*LENGTH +: LENGTH]), 64'(q[k]));
    endtask

    // Drive one cycle, advance the model by the request rules, then check 1ns after the edge.
    task automatic step(input int pc, input int pl, input bit fl,
                        input logic [PUSH_W*LENGTH-1:0] dw, input string ctx);
        int n;
        bit push_acc, pull_acc;
        bus.push_cnt   = 2'(pc);
        bus.pull_cnt   = 2'(pl);
        bus.flush      = fl;
        bus.data_write = dw;
        @(posedge clk);
        n = q.size();
        if (fl) begin
            q.delete();
            m_wp = 0; m_rp = 0;
        end else begin
            push_acc = (pc <= PUSH_W) && (pc <= SIZE - n);
            pull_acc = (pl <= PULL_W) && (pl <= n);
            if (!push_acc) m_ovf = 1;
            if (!pull_acc) m_unf = 1;
            if (pull_acc) begin
                for (int i = 0; i < pl; i++) void'(q.pop_front());
                m_rp = (m_rp + pl) % SIZE;
            end
            if (push_acc) begin
                for (int i = 0; i < pc; i++) q.push_back(dw[i*LENGTH +: LENGTH]);
                m_wp = (m_wp + pc) % SIZE;
            end
        end
        #1;
        bus.push_cnt = '0;
        bus.pull_cnt = '0;
        bus.flush    = 1'b0;
        check_all(ctx);
    endtask

    function automatic logic [PUSH_W*LENGTH-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        bus.flush = 0; bus.push_cnt = '0; bus.pull_cnt = '0; bus.data_write = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_all("reset");

        // Asynchronous reset mid-clock-low with five entries held
        step(2, 0, 0, rnd_data(), "fill5a");
        step(2, 0, 0, rnd_data(), "fill5b");
        step(1, 0, 0, rnd_data(), "fill5c");
        chk("pre_rst.count", 64'(bus.count), 64'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst = 1'b0;

        // Fill with {k+1,k}, then overflow attempt
        for (int k = 0; k < SIZE; k += 2)
            step(2, 0, 0, {32'(k + 1), 32'(k)}, "fill");
        chk("full.count", 64'(bus.count), 64'd8);
        chk("full.flag", 64'(bus.full), 64'd1);
        chk("full.wp", 64'(bus.write_ptr), 64'd0);
        step(1, 0, 0, rnd_data(), "overflow");
        chk("overflow.flag", 64'(bus.overflow_err), 64'd1);

        // Drain in pairs, then underflow attempt
        for (int k = 0; k < SIZE; k += 2) begin
            chk("drain.lane0", 64'(bus.data_read[0 +: LENGTH]), 64'(k));
            chk("drain.lane1", 64'(bus.data_read[LENGTH +: LENGTH]), 64'(k + 1));
            step(0, 2, 0, '0, "drain");
        end
        chk("drain.empty", 64'(bus.empty), 64'd1);
        step(0, 1, 0, '0, "underflow");
        chk("underflow.flag", 64'(bus.underflow_err), 64'd1);
        chk("underflow.rp", 64'(bus.read_ptr), 64'd0);

        // Move pointers to rp=7, wp=0 with one entry, then push 2 + pull 1 across the wrap
        step(2, 0, 0, rnd_data(), "walk"); step(2, 0, 0, rnd_data(), "walk");
        step(2, 0, 0, rnd_data(), "walk"); step(1, 0, 0, rnd_data(), "walk");
        step(0, 2, 0, '0, "walk"); step(0, 2, 0, '0, "walk");
        step(0, 2, 0, '0, "walk"); step(0, 1, 0, '0, "walk");
        step(1, 0, 0, 64'h0000_0000_AAAA_0001, "walk");
        chk("wrap.rp_pre", 64'(bus.read_ptr), 64'd7);
        step(2, 1, 0, {32'hBBBB_0003, 32'hBBBB_0002}, "wrap");
        chk("wrap.count", 64'(bus.count), 64'd2);
        chk("wrap.rp", 64'(bus.read_ptr), 64'd0);
        chk("wrap.lane0", 64'(bus.data_read[0 +: LENGTH]), 64'h0000_0000_BBBB_0002);
        chk("wrap.lane1", 64'(bus.data_read[LENGTH +: LENGTH]), 64'h0000_0000_BBBB_0003);

        // Flush with concurrent push/pull, from a clean reset
        @(negedge clk);
        rst = 1'b1; #1; model_reset(); #1 rst = 1'b0;
        step(2, 0, 0, rnd_data(), "pf"); step(2, 0, 0, rnd_data(), "pf");
        step(1, 0, 0, rnd_data(), "pf");
        step(2, 2, 1, rnd_data(), "flush");
        chk("flush.empty", 64'(bus.empty), 64'd1);
        chk("flush.ovf", 64'(bus.overflow_err), 64'd0);
        chk("flush.unf", 64'(bus.underflow_err), 64'd0);

        // Random traffic, including illegal counts and occasional flush
        for (int i = 0; i < 2000; i++) begin
            int rp, rl;
            rp = $urandom_range(0, 19);
            rl = $urandom_range(0, 19);
            step((rp == 0) ? 3 : rp % 3, (rl == 0) ? 3 : rl % 3,
                 ($urandom_range(0, 49) == 0), rnd_data(), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
